sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO with internally managed read/write pointers.

---
 rtl/sync_fifo_if.sv | 27 ++
 rtl/sync_fifo_param.sv | 48 ++++
 tb/tb_sync_fifo_param.sv | 113 +++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake and status bundle for sync_fifo_param
interface sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with wrap-bit pointers, occupancy count,
// almost-full/empty thresholds and overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input logic       clk,
    input logic       reset,
    sync_fifo_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, count;
    logic              rd_acc, wr_acc;
    assign bus.count        = count;
    assign bus.full         = count == (ADDR_W+1)'(DEPTH);
    assign bus.empty        = count == '0;
    assign bus.almost_full  = count >= (ADDR_W+1)'(AF_LEVEL);
    assign bus.almost_empty = count <= (ADDR_W+1)'(AE_LEVEL);
    // a full FIFO still takes a write when a read frees the slot on the same edge
    assign rd_acc = bus.rd_en && !bus.empty;
    assign wr_acc = bus.wr_en && (!bus.full || rd_acc);
    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
            count         <= count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
            bus.rd_valid  <= rd_acc;
            bus.overflow  <= bus.wr_en && !wr_acc;
            bus.underflow <= bus.rd_en && bus.empty;
        end
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of fill, drain, wrap, simultaneous access and reset.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    sync_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();
    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    // drive one cycle of stimulus, then sample 1 time unit after the edge
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_aempty", 32'(bus.almost_empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_unf", 32'(bus.underflow), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            chk("fill_count", 32'(bus.count), i);
            chk("fill_afull", 32'(bus.almost_full), 32'(i >= 12));
            chk("fill_aempty", 32'(bus.almost_empty), 32'(i <= 4));
            chk("fill_full", 32'(bus.full), 32'(i == 16));
        end
        cyc(1'b1, 8'h99, 1'b0);
        chk("ovf_pulse", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 16);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(bus.overflow), 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(bus.rd_data), i);
            chk("drain_valid", 32'(bus.rd_valid), 1);
            chk("drain_count", 32'(bus.count), 16 - i);
        end
        chk("drain_empty", 32'(bus.empty), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", 32'(bus.underflow), 1);
        chk("unf_valid", 32'(bus.rd_valid), 0);
        chk("unf_hold", 32'(bus.rd_data), 32'h10);
        cyc(1'b0, 8'h00, 1'b0);
        chk("unf_clear", 32'(bus.underflow), 0);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 10; k++) cyc(1'b1, 8'(8'h20 + 8'(p * 16) + 8'(k)), 1'b0);
            chk("wrap_count10", 32'(bus.count), 10);
            for (int k = 0; k < 10; k++) begin
                cyc(1'b0, 8'h00, 1'b1);
                chk("wrap_data", 32'(bus.rd_data), 32'h20 + p * 16 + k);
            end
            chk("wrap_count0", 32'(bus.count), 0);
        end
        for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'h60 + 8'(k)), 1'b0);
        chk("sim_full", 32'(bus.full), 1);
        cyc(1'b1, 8'hAA, 1'b1);
        chk("simf_ovf", 32'(bus.overflow), 0);
        chk("simf_count", 32'(bus.count), 16);
        chk("simf_data", 32'(bus.rd_data), 32'h60);
        chk("simf_valid", 32'(bus.rd_valid), 1);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("simf_drain", 32'(bus.rd_data), (k == 16) ? 32'hAA : 32'h60 + k);
        end
        chk("simf_empty", 32'(bus.empty), 1);
        cyc(1'b1, 8'h55, 1'b1);
        chk("sime_unf", 32'(bus.underflow), 1);
        chk("sime_count", 32'(bus.count), 1);
        chk("sime_valid", 32'(bus.rd_valid), 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("sime_data", 32'(bus.rd_data), 32'h55);
        chk("sime_rvalid", 32'(bus.rd_valid), 1);
        for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h70 + 8'(k)), 1'b0);
        chk("mid_count", 32'(bus.count), 7);
        reset = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1);
        reset = 1'b0;
        chk("mrst_count", 32'(bus.count), 0);
        chk("mrst_empty", 32'(bus.empty), 1);
        chk("mrst_data", 32'(bus.rd_data), 0);
        cyc(1'b1, 8'h3C, 1'b0);
        chk("rt_count", 32'(bus.count), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("rt_data", 32'(bus.rd_data), 32'h3C);
        chk("rt_count0", 32'(bus.count), 0);
        cyc(1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
